// File: rtl/edge_threshold_packer_if.sv
// Stream bundle for edge_threshold_packer: gradient results in, packed edge words out.
// master = the packer, slave = the surrounding upstream/downstream logic.
interface edge_threshold_packer_if;
  logic        i_result_vld;
  logic        i_result_busy;
  logic [23:0] i_result_data;
  logic        o_edge_vld;
  logic        o_edge_busy;
  logic [23:0] o_edge_data;
  logic        o_edge_last;

  modport master (
    input  i_result_vld, i_result_data, o_edge_busy,
    output i_result_busy, o_edge_vld, o_edge_data, o_edge_last
  );

  modport slave (
    output i_result_vld, i_result_data, o_edge_busy,
    input  i_result_busy, o_edge_vld, o_edge_data, o_edge_last
  );
endinterface

// File: rtl/edge_threshold_packer.sv
// Thresholds gradient magnitudes into a 1-bit edge map, packs 24 bits per row-aligned
// output word, counts edge pixels per frame and pulses when a frame completes.
module edge_threshold_packer #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned CNT_W = 17
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  edge_threshold_packer_if.master io,
  input  logic [23:0]             i_thresh,
  output logic                    o_frame_done,
  output logic [CNT_W-1:0]        o_edge_count
);
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [23:0]        thresh_q, thresh_d;
  logic [23:0]        acc_q, acc_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [23:0]        out_data_q, out_data_d;
  logic               out_vld_q, out_vld_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic        row_end;
  logic        word_end;
  logic        beat;
  logic        is_edge;
  logic [23:0] thresh_eff;

  assign row_end  = (col_q == COL_LAST);
  assign word_end = (bit_cnt_q == BIT_LAST) || row_end;

  // Stall only a word-completing beat while the output register is still occupied;
  // depends on registers alone so o_edge_busy never reaches i_result_busy combinationally.
  assign io.i_result_busy = (state_q == S_DONE) || (out_vld_q && word_end);
  assign beat             = io.i_result_vld && !io.i_result_busy;

  // The first beat of a frame compares against the live input, later beats against the latch.
  assign thresh_eff = (state_q == S_IDLE) ? i_thresh : thresh_q;
  assign is_edge    = (io.i_result_data >= thresh_eff);

  always_comb begin
    state_d    = state_q;
    thresh_d   = thresh_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    count_d    = count_q;

    if (out_vld_q && !io.o_edge_busy) begin
      out_vld_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (beat) begin
          if (state_q == S_IDLE) begin
            thresh_d = i_thresh;
            count_d  = CNT_W'(is_edge);
          end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(is_edge);
          end

          acc_d[bit_cnt_q] = is_edge;
          if (word_end) begin
            out_data_d = acc_d;
            out_vld_d  = 1'b1;
            out_last_d = row_end;
            acc_d      = '0;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end

          state_d = S_RUN;
          if (row_end) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!out_vld_q) begin
          done_d  = 1'b1;
          row_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      thresh_q   <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      thresh_q   <= thresh_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign io.o_edge_vld  = out_vld_q;
  assign io.o_edge_data = out_data_q;
  assign io.o_edge_last = out_last_q;
  assign o_frame_done   = done_q;
  assign o_edge_count   = count_q;
endmodule

// File: doc/edge_threshold_packer.md
Name: edge_threshold_packer

Overview:
- Stage directly downstream of the image-gradient stage; consumes its 24-bit result stream.
- Compares each result (an unsigned gradient magnitude) against a per-frame threshold to form a 1-bit edge map.
- Packs edge bits 24 per output word, row-aligned, for the result writer.
- Counts edge pixels per frame and pulses on frame completion.

Parameters:
- IMG_W, 256, pixels per row (>=1).
- IMG_H, 256, rows per frame (>=1).
- CNT_W, 17, width of o_edge_count; must be >= clog2(IMG_W*IMG_H+1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-low reset.
- i_result_busy  output  1  stall to upstream; a beat transfers when i_result_vld=1 and i_result_busy=0 at a rising edge.
- i_result_vld  input  1  upstream data valid.
- i_result_data  input  24  unsigned gradient magnitude.
- o_edge_busy  input  1  downstream stall.
- o_edge_vld  output  1  packed word valid.
- o_edge_data  output  24  packed edge bits; bit k = pixel k of the word.
- o_edge_last  output  1  qualifies o_edge_data as the last word of a row.
- i_thresh  input  24  edge threshold; sampled on the first beat of each frame.
- o_frame_done  output  1  one-cycle pulse at end of frame.
- o_edge_count  output  CNT_W  edge-pixel count of the frame; holds until the next frame's first beat.

Behaviour:
- Reset (i_rst=0, asynchronous): FSM to IDLE; accumulator, bit/col/row counters and o_edge_data cleared to 0; o_edge_vld, o_edge_last, o_frame_done, o_edge_count and i_result_busy all 0. A partial word or partial frame in flight is discarded.
- Edge rule: edge = (i_result_data >= threshold), unsigned 24-bit compare.
  - Threshold register loads i_thresh on the frame's first accepted beat.
  - Changes to i_thresh mid-frame are ignored.
- FSM states:
  - IDLE: i_result_busy=0. First beat latches the threshold, clears the count to 0 (then counts that beat), and moves to RUN.
  - RUN: each accepted beat sets acc[bit_cnt]=edge, increments bit_cnt, increments col, and adds edge to the count.
    - Word completes when bit_cnt==23 or col==IMG_W-1.
    - On completion, the accumulator (unused high bits 0) moves to the output register: o_edge_vld=1, o_edge_last=(col==IMG_W-1).
    - bit_cnt then resets to 0.
    - At row end, col resets to 0 and row increments.
    - When row end coincides with row==IMG_H-1, go to DONE.
  - DONE: i_result_busy=1. Once the output register is empty (o_edge_vld=0), pulse o_frame_done for one cycle, reset row to 0 and return to IDLE.
- Output register:
  - A word transfers when o_edge_vld & !o_edge_busy; o_edge_vld then clears.
  - o_edge_data and o_edge_last hold stable while o_edge_vld=1 and o_edge_busy=1.
- Backpressure:
  - In IDLE/RUN, i_result_busy = o_edge_vld & (bit_cnt==23 | col==IMG_W-1). It is driven from registers only, with no combinational path from o_edge_busy.
  - A word-completing beat is therefore accepted only when the output register is empty. This costs at least one bubble per word when back-to-back.
  - Non-completing beats keep flowing while a word waits downstream.
- Latency: the beat completing a word appears on o_edge_vld the next cycle.
- Word count per row: ceil(IMG_W/24) (256 -> 11 words: 10 full, 1 with bits[15:0] valid).
- o_edge_count saturates at all-ones (unreachable when CNT_W is legal).
- o_frame_done rises exactly one cycle after the last word transfers, or the cycle after DONE entry if that word has already left.

Test Plan:
- IMG_W=30, IMG_H=2, i_thresh=100, pixels alternating 99,100 with o_edge_busy=0 -> per row: word 0xAAAAAA last=0, then 0x00002A last=1. Frame total: 4 words, o_edge_count=30, single o_frame_done pulse.
- Same config, o_edge_busy=1 held -> first word held stable; pixels 24..28 accepted; i_result_busy=1 before pixel 29. Drop o_edge_busy -> word 0 transfers; i_result_busy falls the following cycle; pixel 29 accepted.
- i_thresh=0, all data 0 -> every word all-ones in valid bits (0xFFFFFF, 0x00003F), count=60. Also i_thresh=0xFFFFFF, data=0xFFFFFE -> all words 0, count=0.
- i_thresh changed 100->0 after pixel 5 of row 0, data=50 -> all bits 0 for the whole frame, count=0. The next frame uses threshold 0.
- Assert i_rst mid-row 1 with o_edge_vld=1 -> all outputs 0 immediately. After release, a fresh frame produces correct words and count with no residue.
- Two frames back-to-back with 7 and 12 edges -> o_edge_count=7 holds after the first o_frame_done; count restarts at the next frame's first beat and reads 12 at the second pulse.
